// File: rtl/apb_slave_regfile.sv
// APB completer with a bank of read/write registers, a programmable
// number of wait states and an error response for unmapped addresses.
module apb_slave_regfile #(
    parameter int DATA_WD  = 8,
    parameter int ADDR_WD  = 8,
    parameter int REG_NUM  = 16,
    parameter int WAIT_CYC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [ADDR_WD-1:0] paddr,
    input  logic [DATA_WD-1:0] pwdata,
    output logic [DATA_WD-1:0] prdata,
    output logic               pready,
    output logic               pslverr
);

    localparam int IDX_WD = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    // One extra bit so REG_NUM == 2**ADDR_WD still compares correctly.
    localparam logic [ADDR_WD:0] REG_LIM  = (ADDR_WD + 1)'(REG_NUM);
    localparam logic [3:0]       CNT_INIT = 4'(WAIT_CYC);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [DATA_WD-1:0] regs_q [REG_NUM];
    logic [DATA_WD-1:0] regs_d [REG_NUM];

    logic               setup;
    logic               hit;
    logic               ready;
    logic               wr_en;
    logic               rd_en;
    logic [IDX_WD-1:0]  idx;
    logic [DATA_WD-1:0] rd_data;

    assign setup = psel && !penable;
    assign hit   = {1'b0, paddr} < REG_LIM;
    assign idx   = paddr[IDX_WD-1:0];
    assign ready = (state_q == ACCESS) && psel && penable
                   && (cnt_q == 4'd0);
    assign wr_en = ready && pwrite && hit;
    assign rd_en = ready && !pwrite && hit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_INIT;
                end
            end
            ACCESS: begin
                if (!psel || !penable) begin
                    if (setup) begin
                        state_d = ACCESS;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[idx] = pwdata;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            rd_data = regs_q[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
        end
    end

    assign pready  = ready;
    assign pslverr = ready && !hit;
    assign prdata  = rd_data;

endmodule

// File: doc/apb_slave_regfile.md
# apb_slave_regfile

APB completer that terminates the bus driven by the team's APB master: a bank of `REG_NUM` read/write registers with a programmable number of wait states and an error response for out-of-range addresses. It sits directly downstream of the master, on `psel`/`penable`/`pwrite`/`paddr`/`pwdata`, and returns `prdata`/`pready`. `pslverr` is an extra output that the current master leaves unconnected.

## Interface
Parameters:
- `DATA_WD`, default 8: data width (prdata/pwdata).
- `ADDR_WD`, default 8: address width.
- `REG_NUM`, default 16: number of registers, at addresses 0..REG_NUM-1. Constraint: `REG_NUM <= 2**ADDR_WD`.
- `WAIT_CYC`, default 0: wait cycles inserted before `pready` in every access phase. Range 0..15.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `psel` in 1: slave select.
- `penable` in 1: access phase.
- `pwrite` in 1: 1 = write, 0 = read.
- `paddr` in ADDR_WD: register address (word index).
- `pwdata` in DATA_WD: write data.
- `prdata` out DATA_WD: read data, valid only while `pready` is high on a read.
- `pready` out 1: transfer completes in this cycle.
- `pslverr` out 1: error response, valid only with `pready`.

## Operation
- State machine, two states:
  - IDLE (reset state).
  - ACCESS.
- Counter: `cnt`, 4 bits, reset value 0.
- IDLE -> ACCESS when `psel && !penable` (setup phase). On the same edge, `cnt` loads `WAIT_CYC`.
- In IDLE, `psel && penable` with no preceding setup phase is a protocol error:
  - ignored;
  - `pready` stays 0;
  - no register change.
- ACCESS behaviour:
  - If `!psel || !penable`: abort. Go to IDLE, no write, `pready` 0. If this cycle is a new setup (`psel && !penable`), go to ACCESS instead and reload `cnt`.
  - Else if `cnt != 0`: `cnt` decrements; `pready` = 0.
  - Else (`cnt == 0`): `pready` = 1 combinationally; go to IDLE on the next edge.
- `pready` = (state == ACCESS) && psel && penable && (cnt == 0). It is purely a function of registered state and the inputs.
- Address check: `hit` = (paddr < REG_NUM), compared at full `ADDR_WD` width with no truncation.
- Write commits on the edge where `pready && pwrite && hit`: `reg[paddr] <= pwdata`. Any other cycle leaves the registers unchanged.
- Read: `prdata` = `reg[paddr]` when `pready && !pwrite && hit`; otherwise 0.
- `pslverr` = `pready && !hit`:
  - out-of-range write is dropped;
  - out-of-range read returns 0.
- `paddr`, `pwrite` and `pwdata` are assumed stable from setup through completion. The slave samples them only in the completion cycle.

## Timing
- Reset values:
  - state IDLE, `cnt` 0, all registers 0;
  - `pready` 0, `pslverr` 0, `prdata` 0.
- `rst_n` low mid-transfer: on the next edge, state goes to IDLE and all registers clear. An in-flight write is lost; no `pready` is issued.
- Latency, counted from the setup cycle (cycle S):
  - first access cycle is S+1;
  - `pready` is high in cycle S+1+WAIT_CYC, for exactly one cycle;
  - register update is visible on a read issued at any later setup.
- With the master as driver: `cmd_fire` at cycle T gives setup at T+1 and completion at T+2+WAIT_CYC. The master's `read_vld`/`read_data` sample `prdata` in that same cycle.
- Back-to-back traffic:
  - a setup phase in the cycle right after completion is accepted (IDLE sees setup);
  - the master itself inserts one IDLE cycle between transfers, and both patterns must work.
- Read-after-write to the same address in consecutive transfers returns the new value.

## Test plan
- Reset, then WAIT_CYC=0: write addr 3 data 0xA5 -> `pready` high in the first access cycle, `pslverr` 0. Then read addr 3 -> `prdata` 0xA5 with `pready`; master `read_vld`=1, `read_data`=0xA5.
- WAIT_CYC=3: read addr 0 after reset -> `pready` stays 0 for 3 access cycles, high in the 4th, `prdata` 0x00. Count the exact cycle from setup: S+4.
- Out of range, REG_NUM=16: write addr 0x20 data 0xFF -> `pready`=1, `pslverr`=1, no register changes. Read addr 0x20 -> `prdata` 0, `pslverr` 1.
- Abort: WAIT_CYC=2; drop `psel` in the 2nd access cycle of a write to addr 5 data 0x11 -> no `pready`. A later read of addr 5 returns 0x00.
- Reset mid-transfer: with WAIT_CYC=2, assert `rst_n`=0 one cycle into access for a write to addr 1 data 0x3C -> `pready` never asserts. After release, a read of addr 1 returns 0x00 and a read of a previously written addr also returns 0x00.
- Back-to-back with no idle cycle: write addr 2 data 0x5A, then setup a read of addr 2 in the cycle right after completion -> read completes and returns 0x5A.
